// File: rtl/a0_uart_tx.sv
// a0_uart_tx: serialises each new value of register a0 (x10) onto a UART 8N1 line, MSB byte first.
// Optional: define A0_UART_TX_HEADER_EN to prefix every word with the sync byte 0xA5.
module a0_uart_tx #(
    parameter int unsigned D_WIDTH      = 32,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] a0,
    input  logic               send,
    output logic               tx,
    output logic               busy,
    output logic [7:0]         drop_cnt
);
    localparam int unsigned BYTES = D_WIDTH / 8;
`ifdef A0_UART_TX_HEADER_EN
    localparam int unsigned HDR = 1;
`else
    localparam int unsigned HDR = 0;
`endif
    localparam int unsigned FRAMES = BYTES + HDR;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAMES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e              state_q, state_d;
    logic [D_WIDTH-1:0]  ref_q, ref_d;
    logic [D_WIDTH-1:0]  shift_q, shift_d;
    logic [D_WIDTH-1:0]  pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic                capture;
    int unsigned         data_idx;
    logic [D_WIDTH-1:0]  word_sh;
    logic [7:0]          cur_byte;

    assign capture = (a0 != ref_q) || send;

    // Next-state, capture/pending handling and next-cycle line value
    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        drop_cnt_d   = drop_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    shift_d      = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = START;
                    byte_idx_d   = '0;
                    baud_cnt_d   = '0;
                    // A capture on the drain edge refills the slot; nothing is dropped
                    if (capture) begin
                        pend_d       = a0;
                        ref_d        = a0;
                        pend_valid_d = 1'b1;
                    end
                end else if (capture) begin
                    shift_d    = a0;
                    ref_d      = a0;
                    state_d    = START;
                    byte_idx_d = '0;
                    baud_cnt_d = '0;
                end
            end
            START: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && capture) begin
            if (pend_valid_q && drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
            pend_d       = a0;
            ref_d        = a0;
            pend_valid_d = 1'b1;
        end

        data_idx = 32'(byte_idx_d) - HDR;
        word_sh  = shift_d << (8 * data_idx);
        cur_byte = word_sh[D_WIDTH-1 -: 8];
`ifdef A0_UART_TX_HEADER_EN
        if (byte_idx_d == '0) begin
            cur_byte = 8'hA5;
        end
`endif
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: a word-level timing model predicts tx/busy/drop_cnt every cycle,
// and a small line receiver decodes frames for the directed scenarios.
module tb_a0_uart_tx;
    localparam int D_WIDTH = 32;
    localparam int CPB     = 4;
    localparam int BYTES   = D_WIDTH / 8;
`ifdef A0_UART_TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int WORD = (BYTES + HDR) * 10 * CPB;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [D_WIDTH-1:0] a0;
    logic               send;
    logic               tx;
    logic               busy;
    logic [7:0]         drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    a0_uart_tx #(.D_WIDTH(D_WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .a0(a0), .send(send),
        .tx(tx), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level at offset e cycles into a word, from the frame layout alone
    function automatic logic line_bit(input logic [31:0] w, input int e);
        int f, p;
        logic [7:0] b;
        f = e / (10 * CPB);
        p = (e % (10 * CPB)) / CPB;
        if (HDR == 1 && f == 0) b = 8'hA5;
        else                    b = 8'(w >> (8 * (BYTES - 1 - (f - HDR))));
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    // Reference model: a word occupies the line for WORD cycles; one pending slot
    logic [31:0] m_ref, m_pend, m_word;
    logic        m_pv, m_cap;
    int          m_left, m_drop;
    int          busy_run = 0, last_run = 0;
    logic        exp_tx;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ref = '0; m_left = 0; m_pv = 1'b0; m_drop = 0;
        end else begin
            m_cap = (a0 != m_ref) || send;
            if (m_left == 0) begin
                if (m_pv) begin
                    m_word = m_pend; m_left = WORD; m_pv = 1'b0;
                    if (m_cap) begin m_pend = a0; m_ref = a0; m_pv = 1'b1; end
                end else if (m_cap) begin
                    m_word = a0; m_ref = a0; m_left = WORD;
                end
            end else begin
                m_left--;
                if (m_cap) begin
                    if (m_pv && m_drop != 255) m_drop++;
                    m_pend = a0; m_ref = a0; m_pv = 1'b1;
                end
            end
        end
        #1;
        exp_tx = (m_left > 0) ? line_bit(m_word, WORD - m_left) : 1'b1;
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (busy === 1'b1) busy_run++;
        else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        if (n >= 4000) chk("wait_idle timeout", 32'(busy), 32'd0);
    endtask

    task automatic rx_byte(input logic [7:0] exp, input string tag);
        int n = 0;
        logic [7:0] b;
        while (tx !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        if (n >= 4000) begin
            chk({tag, " start timeout"}, 32'(tx), 32'd0);
            return;
        end
        tick(CPB / 2);
        for (int i = 0; i < 8; i++) begin
            tick(CPB);
            b[i] = tx;
        end
        tick(CPB);
        chk({tag, " stop"}, 32'(tx), 32'd1);
        chk({tag, " byte"}, 32'(b), 32'(exp));
    endtask

    task automatic rx_word(input logic [31:0] w, input string tag);
        logic [31:0] t;
        t = w;
        if (HDR == 1) rx_byte(8'hA5, {tag, " hdr"});
        for (int i = 0; i < BYTES; i++) begin
            rx_byte(t[31:24], tag);
            t = t << 8;
        end
    endtask

    initial begin
        rst_n = 1'b0; a0 = '0; send = 1'b0;
        tick(3);
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(200);
        chk("idle zero a0 busy", 32'(busy), 32'd0);

        // New value, then three overwrites during the word
        a0 = 32'h1234_5678;
        fork
            rx_word(32'h1234_5678, "word1");
            begin
                tick(40); a0 = 32'h1;
                tick(40); a0 = 32'h2;
                tick(40); a0 = 32'h3;
            end
        join
        wait_idle();
        chk("word1 busy length", 32'(last_run), 32'(WORD));
        tick(1);
        chk("one idle cycle gap", 32'(busy), 32'd1);
        rx_word(32'h3, "pending");
        wait_idle();
        chk("drop_cnt two", 32'(drop_cnt), 32'd2);

        // Explicit retransmit of an unchanged value
        tick(20);
        send = 1'b1; tick(1); send = 1'b0;
        rx_word(32'h3, "resend");
        wait_idle();
        tick(300);
        chk("no spontaneous frame", 32'(busy), 32'd0);

        // Reset in the middle of a data bit
        a0 = 32'hCAFE_F00D;
        tick(20);
        rst_n = 1'b0; a0 = 32'h3;
        tick(1);
        chk("mid reset tx", 32'(tx), 32'd1);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("restart busy", 32'(busy), 32'd1);
        chk("restart tx", 32'(tx), 32'd0);
        wait_idle();

        // Saturating overwrite counter
        a0 = 32'h1000;
        tick(1);
        for (int i = 0; i < 300; i++) begin
            a0 = 32'h2000 + 32'(i);
            tick(1);
        end
        chk("drop_cnt saturates", 32'(drop_cnt), 32'd255);

        // Random traffic: changes, send pulses, occasional reset
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) a0 = (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)));
            send  = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 699) != 0);
            tick(1);
        end
        send = 1'b0; rst_n = 1'b1;
        tick(2 * WORD + 10);
        wait_idle();
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/a0_uart_tx.md
# a0_uart_tx

Debug result transmitter for the single-cycle core. It watches the register file's `a0` output and serialises every new value onto a UART 8N1 line, so test programs can report results off-chip. It sits beside the register file and consumes only its `a0` read-out. It is the reader and transmitter for the value the core writes into `x10`.

## Interface
- `D_WIDTH`, 32, width of `a0`; must be a multiple of 8; `BYTES = D_WIDTH/8`.
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `a0`  in  D_WIDTH  live value of register `x10`.
- `send`  in  1  one-cycle request to transmit the current `a0` even if unchanged.
- `tx`  out  1  UART line; idle high.
- `busy`  out  1  high while a word is being shifted out.
- `drop_cnt`  out  8  count of pending values overwritten before transmission; saturates at 255.

## Operation
- **State machine:** IDLE, START, DATA, STOP.
- **Internal state:**
  - `ref`: last value captured for sending or pending.
  - `shift`: word in flight.
  - `pend`/`pend_valid`: one-deep pending slot.
  - `baud_cnt`, `bit_idx` (0–7), `byte_idx` (0–BYTES-1).
- **Capture condition:** `a0 != ref`, or `send == 1`.
  - In IDLE, a capture loads `shift` and `ref`, then moves to START with `byte_idx = 0`.
  - When not IDLE, a capture loads `pend` and `ref` and sets `pend_valid`.
  - If `pend_valid` was already set, `pend` is overwritten and `drop_cnt` increments, saturating at 255.
- **Byte order:** most-significant byte first. Within a byte, LSB first.
- **Frame per byte:**
  - START: `tx = 0` for CLKS_PER_BIT cycles.
  - DATA: 8 bits, each held CLKS_PER_BIT cycles.
  - STOP: `tx = 1` for CLKS_PER_BIT cycles.
  - There is no gap between bytes of one word.
- **After the final STOP:**
  - The block goes to IDLE.
  - If `pend_valid` is set, it stays in IDLE exactly one cycle (`tx = 1`), then moves `pend` to `shift`, clears `pend_valid`, and enters START.
- **Priority:** a capture on the same edge that `pend` is drained goes into `pend`, so the value is not lost.
- **`busy`:** high in START/DATA/STOP, low in IDLE.
- **Reset:**
  - `tx = 1`, `busy = 0`, `drop_cnt = 0`, `ref = 0`, `pend_valid = 0`, state IDLE.
  - A frame interrupted by reset is abandoned with no completion.
  - After reset, a nonzero `a0` triggers a capture because `ref = 0`.

## Timing
- **Latency:** `a0` sampled different at edge N → `tx` falls and `busy` rises after edge N (registered outputs, one-cycle latency).
- **Word duration:** BYTES × 10 × CLKS_PER_BIT cycles from start fall to end of the last stop bit. With the defaults this is 640 cycles.
- **`busy` timing:** falls on the edge that ends the last stop bit.
- **Back-to-back words:** separated by exactly one idle cycle.
- **Bit timing:** `baud_cnt` counts 0..CLKS_PER_BIT-1; the bit advances when the count reaches CLKS_PER_BIT-1.
- **`send` while busy:** behaves as a capture of the current `a0` into `pend`.
- **`send` with `a0` unchanged in IDLE:** retransmits.

## Configuration
- **`A0_UART_TX_HEADER_EN` defined:**
  - Every word is preceded by the sync byte 0xA5, using the same frame format with no gap.
  - Word duration becomes (BYTES+1) × 10 × CLKS_PER_BIT.
  - `byte_idx` range is 0..BYTES.
- **Undefined:** only the BYTES data bytes are sent.

## Test plan
All scenarios use CLKS_PER_BIT=4 and D_WIDTH=32 with the macro undefined, except scenario 6.

1. Reset, then hold `a0=0` for 200 cycles → `tx=1`, `busy=0`, `drop_cnt=0` throughout.
2. Set `a0=0x12345678` at edge N → `tx` falls after edge N and the line carries bytes 0x12, 0x34, 0x56, 0x78 (LSB first, start/stop correct). `busy` is high for exactly 160 cycles.
3. During scenario 2's word, step `a0` to 0x1, 0x2, then 0x3 → after the first word, one idle cycle, then 0x00000003 is sent. `drop_cnt=2`; 0x1 and 0x2 are never transmitted.
4. In IDLE with `a0=0x3` unchanged, pulse `send` → 0x00000003 is retransmitted. Holding `a0` with no `send` produces no further frames.
5. Deassert `rst_n` mid-DATA of a word → `tx=1` and `busy=0` after that edge, and `drop_cnt=0`. Release with `a0=0x3` → a new word starts one cycle later.
6. With 300 overwrites while busy, `drop_cnt` saturates at 255. With `A0_UART_TX_HEADER_EN` defined, `a0=0xDEADBEEF` → bytes 0xA5, 0xDE, 0xAD, 0xBE, 0xEF, with `busy` high for 200 cycles.
